pong_match_ctrl: RTL and testbench

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

---
 rtl/pong_match_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl
// ---------------
// Match sequencer for a two-player pong game. It tracks both scores, runs the
// serve delay, handles pause, declares the winner and picks the ball speed
// level from whichever player is currently ahead.
//
// Ports
//   sys_clk     single clock, everything changes on its rising edge
//   reset       synchronous, active-high
//   start_btn   debounced level, rising edge starts/restarts a match
//   pause_btn   debounced level, rising edge toggles pause during play
//   frame_tick  one-cycle pulse per video frame
//   p1_point    one-cycle pulse, player 1 scored
//   p2_point    one-cycle pulse, player 2 scored
//   ball_run    ball engine advances only while high
//   ball_load   one-cycle pulse that recentres the ball
//   serve_dir   0 serves toward player 1 (left), 1 toward player 2 (right)
//   speed_lvl   ball speed level 0..2
//   p1_score    player 1 score
//   p2_score    player 2 score
//   winner      00 none, 01 player 1, 10 player 2
//   state_o     current state encoding

module pong_match_ctrl #(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int LVL1_SCORE   = 4,
    parameter int LVL2_SCORE   = 8
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       frame_tick,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic       ball_run,
    output logic       ball_load,
    output logic       serve_dir,
    output logic [1:0] speed_lvl,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] winner,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SERVE  = 3'd2,
        PLAY   = 3'd3,
        PAUSED = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [3:0] WIN_VAL   = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_VAL = 8'(SERVE_FRAMES);
    localparam logic [4:0] LVL1_VAL  = 5'(LVL1_SCORE);
    localparam logic [4:0] LVL2_VAL  = 5'(LVL2_SCORE);

    state_t     state_q, state_d;
    logic [7:0] serve_cnt_q, serve_cnt_d;
    logic [3:0] p1_q, p1_d;
    logic [3:0] p2_q, p2_d;
    logic [1:0] winner_q, winner_d;
    logic       dir_q, dir_d;
    logic [1:0] lvl_q, lvl_d;
    logic       start_prev_q, pause_prev_q;
    logic       start_rise, pause_rise;
    logic [3:0] lead_score;

    // Button edges come from comparing each level with last cycle's value.
    // The previous-value registers reset to 1 so a button held through
    // reset does not look like a fresh press.
    assign start_rise = start_btn & ~start_prev_q;
    assign pause_rise = pause_btn & ~pause_prev_q;

    assign lead_score = (p1_q >= p2_q) ? p1_q : p2_q;

    // Next-state and datapath decisions. Points win over a simultaneous
    // pause press, and a double point replays the rally without scoring.
    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        winner_d    = winner_q;
        dir_d       = dir_q;

        if ({1'b0, lead_score} < LVL1_VAL) begin
            lvl_d = 2'd0;
        end else if ({1'b0, lead_score} < LVL2_VAL) begin
            lvl_d = 2'd1;
        end else begin
            lvl_d = 2'd2;
        end

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                serve_cnt_d = 8'd0;
                state_d     = SERVE;
            end
            SERVE: begin
                if (frame_tick) begin
                    serve_cnt_d = serve_cnt_q + 8'd1;
                    if (serve_cnt_q + 8'd1 == SERVE_VAL) begin
                        state_d = PLAY;
                    end
                end
            end
            PLAY: begin
                if (p1_point && p2_point) begin
                    state_d = LOAD;
                end else if (p1_point) begin
                    p1_d = p1_q + 4'd1;
                    if (p1_q + 4'd1 == WIN_VAL) begin
                        winner_d = 2'b01;
                        state_d  = DONE;
                    end else begin
                        dir_d   = 1'b1;
                        state_d = LOAD;
                    end
                end else if (p2_point) begin
                    p2_d = p2_q + 4'd1;
                    if (p2_q + 4'd1 == WIN_VAL) begin
                        winner_d = 2'b10;
                        state_d  = DONE;
                    end else begin
                        dir_d   = 1'b0;
                        state_d = LOAD;
                    end
                end else if (pause_rise) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (pause_rise) begin
                    state_d = PLAY;
                end
            end
            DONE: begin
                if (start_rise) begin
                    p1_d     = 4'd0;
                    p2_d     = 4'd0;
                    winner_d = 2'b00;
                    dir_d    = 1'b0;
                    lvl_d    = 2'd0;
                    state_d  = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. The speed level register samples the
    // already-registered scores, so it trails a score change by one cycle.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            serve_cnt_q  <= 8'd0;
            p1_q         <= 4'd0;
            p2_q         <= 4'd0;
            winner_q     <= 2'b00;
            dir_q        <= 1'b0;
            lvl_q        <= 2'd0;
            start_prev_q <= 1'b1;
            pause_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            serve_cnt_q  <= serve_cnt_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            winner_q     <= winner_d;
            dir_q        <= dir_d;
            lvl_q        <= lvl_d;
            start_prev_q <= start_btn;
            pause_prev_q <= pause_btn;
        end
    end

    assign ball_run  = (state_q == PLAY);
    assign ball_load = (state_q == LOAD);
    assign serve_dir = dir_q;
    assign speed_lvl = lvl_q;
    assign p1_score  = p1_q;
    assign p2_score  = p2_q;
    assign winner    = winner_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl
// ------------------
// Directed bench for pong_match_ctrl with default parameters
// (WIN_SCORE 9, SERVE_FRAMES 60, LVL1 4, LVL2 8). Inputs change just after
// a rising edge and outputs are sampled 1 ns after the edge.

module tb_pong_match_ctrl;

    localparam int ST_IDLE   = 0;
    localparam int ST_LOAD   = 1;
    localparam int ST_SERVE  = 2;
    localparam int ST_PLAY   = 3;
    localparam int ST_PAUSED = 4;
    localparam int ST_DONE   = 5;

    logic       sys_clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       p1_point = 1'b0;
    logic       p2_point = 1'b0;
    logic       ball_run;
    logic       ball_load;
    logic       serve_dir;
    logic [1:0] speed_lvl;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] winner;
    logic [2:0] state_o;

    int checkCount = 0;
    int failCount  = 0;

    pong_match_ctrl dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .start_btn  (start_btn),
        .pause_btn  (pause_btn),
        .frame_tick (frame_tick),
        .p1_point   (p1_point),
        .p2_point   (p2_point),
        .ball_run   (ball_run),
        .ball_load  (ball_load),
        .serve_dir  (serve_dir),
        .speed_lvl  (speed_lvl),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .winner     (winner),
        .state_o    (state_o)
    );

    // 100 MHz clock
    always #5 sys_clk = ~sys_clk;

    // Counts one comparison and reports it if the observed value is wrong.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle's worth of inputs and moves to just after the next edge.
    task automatic applyStimulus(input logic st, input logic pa, input logic ft,
                                 input logic p1, input logic p2);
        start_btn  = st;
        pause_btn  = pa;
        frame_tick = ft;
        p1_point   = p1;
        p2_point   = p2;
        @(posedge sys_clk);
        #1;
    endtask

    // From LOAD: one cycle into SERVE, then 60 frame ticks spaced by idle
    // cycles; the ball must stay parked until the 60th tick.
    task automatic serveToPlay(input string tag);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput({tag, " serve state"}, state_o, ST_SERVE);
        for (int i = 0; i < 59; i++) begin
            applyStimulus(0, 0, 1, 0, 0);
            applyStimulus(0, 0, 0, 0, 0);
        end
        checkOutput({tag, " run before 60th tick"}, ball_run, 0);
        checkOutput({tag, " still serve at 59"}, state_o, ST_SERVE);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput({tag, " play state"}, state_o, ST_PLAY);
        checkOutput({tag, " run at 60th tick"}, ball_run, 1);
    endtask

    // Player 1 scores a non-winning point and the next serve completes.
    task automatic p1Rally(input int newScore);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("p1 rally score", p1_score, newScore);
        checkOutput("p1 rally state", state_o, ST_LOAD);
        checkOutput("p1 rally dir", serve_dir, 1);
        serveToPlay("p1 rally");
    endtask

    initial begin
        // Reset state
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("reset state", state_o, ST_IDLE);
        checkOutput("reset run", ball_run, 0);
        checkOutput("reset load", ball_load, 0);
        checkOutput("reset scores", {p1_score, p2_score}, 0);
        checkOutput("reset winner", winner, 0);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);

        // Pause and points are ignored in IDLE
        applyStimulus(0, 1, 0, 1, 1);
        checkOutput("idle ignores pause/points", state_o, ST_IDLE);
        checkOutput("idle p1 unchanged", p1_score, 0);

        // Start a match
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("start -> load", state_o, ST_LOAD);
        checkOutput("load pulse", ball_load, 1);
        serveToPlay("first serve");
        checkOutput("load pulse one cycle", ball_load, 0);

        // Player 2 scores
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("p2 point score", p2_score, 1);
        checkOutput("p2 point dir", serve_dir, 0);
        checkOutput("p2 point state", state_o, ST_LOAD);
        serveToPlay("after p2");

        // Player 1 scores four times; speed level trails by one cycle
        p1Rally(1);
        p1Rally(2);
        p1Rally(3);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("p1=4 score", p1_score, 4);
        checkOutput("speed before update", speed_lvl, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("speed one cycle later", speed_lvl, 1);
        checkOutput("serve after p1=4", state_o, ST_SERVE);
        for (int i = 0; i < 60; i++) begin
            applyStimulus(0, 0, 1, 0, 0);
            applyStimulus(0, 0, 0, 0, 0);
        end
        checkOutput("play after p1=4", state_o, ST_PLAY);

        // Double point: no score change, serve_dir unchanged
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("double point state", state_o, ST_LOAD);
        checkOutput("double point p1", p1_score, 4);
        checkOutput("double point p2", p2_score, 1);
        checkOutput("double point dir", serve_dir, 1);
        serveToPlay("after double");

        // Pause, ignored point, unpause
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("paused state", state_o, ST_PAUSED);
        checkOutput("paused run", ball_run, 0);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("paused point ignored", p1_score, 4);
        checkOutput("paused holds", state_o, ST_PAUSED);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("unpause state", state_o, ST_PLAY);
        checkOutput("unpause run", ball_run, 1);
        applyStimulus(0, 0, 0, 0, 0);

        // Pause edge with a point: the point wins
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("pause+point score", p1_score, 5);
        checkOutput("pause+point state", state_o, ST_LOAD);
        serveToPlay("after pause+point");

        // Play on to a player 1 win
        p1Rally(6);
        p1Rally(7);
        p1Rally(8);
        checkOutput("speed level 2", speed_lvl, 2);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("win state", state_o, ST_DONE);
        checkOutput("win score", p1_score, 9);
        checkOutput("winner p1", winner, 1);
        checkOutput("done run", ball_run, 0);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("done ignores point", p2_score, 1);
        checkOutput("done ignores pause", state_o, ST_DONE);
        checkOutput("score capped", p1_score, 9);
        applyStimulus(0, 0, 0, 0, 0);

        // Restart from DONE clears the match
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("restart state", state_o, ST_LOAD);
        checkOutput("restart scores", {p1_score, p2_score}, 0);
        checkOutput("restart winner", winner, 0);
        checkOutput("restart speed", speed_lvl, 0);
        checkOutput("restart dir", serve_dir, 0);

        // Reset mid-SERVE with start held high
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("serve with start held", state_o, ST_SERVE);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 1, 0, 0);
        end
        reset = 1'b1;
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("mid-serve reset state", state_o, ST_IDLE);
        checkOutput("mid-serve reset outputs",
                    {ball_run, ball_load, serve_dir, speed_lvl, p1_score, p2_score, winner}, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
        end
        checkOutput("held start no edge", state_o, ST_IDLE);

        // Fresh start after release; serve counter starts from zero again
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("post-reset start", state_o, ST_LOAD);
        serveToPlay("post-reset serve");

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
